// File: rtl/prefetch_stream_fifo.sv
// rtl/prefetch_stream_fifo.sv - BRAM-backed valid/ready FIFO with a prefetch slot ring at the head
// Entries enter the slot ring directly when the BRAM is empty; otherwise they are refetched in order.
module prefetch_stream_fifo #(
  parameter int DEPTH        = 512,
  parameter int DWIDTH       = 64,
  parameter int RD_LAT       = 2,
  parameter int NB_PF        = RD_LAT + 2,
  parameter int AFULL_THRESH = DEPTH - 8,
  parameter int AWIDTH       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AWIDTH:0]   occup,
  output logic              almost_full,
  output logic              overflow
);

  localparam int SW = $clog2(NB_PF);
  localparam int CW = $clog2(NB_PF + 1);
  localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH:0] AFULL_C = (AWIDTH + 1)'(AFULL_THRESH);
  localparam logic [CW-1:0]   NB_PF_C = CW'(NB_PF);
  localparam logic [SW-1:0]   LAST_SLOT = SW'(NB_PF - 1);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr, rd_ptr;
  logic [AWIDTH:0]   bram_cnt, occup_nxt;

  // Slot ring: a slot is reserved (alloc) either by a bypass push or by a BRAM read issue.
  logic [DWIDTH-1:0] slot_data [NB_PF];
  logic [NB_PF-1:0]  slot_vld;
  logic [SW-1:0]     head, alloc;
  logic [CW-1:0]     alloc_cnt;

  logic [RD_LAT-1:0] pipe_vld;
  logic [SW-1:0]     pipe_idx  [RD_LAT];
  logic [DWIDTH-1:0] pipe_data [RD_LAT];

  logic push, pop, bypass, to_bram, issue, ret;
  logic [SW-1:0] ret_idx;

  function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] i);
    return (i == LAST_SLOT) ? '0 : i + 1'b1;
  endfunction

  assign out_valid = slot_vld[head];
  assign out_data  = slot_data[head];

  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign bypass    = push && (bram_cnt == '0) && (alloc_cnt < NB_PF_C);
  assign to_bram   = push && !bypass;
  assign issue     = !flush && (bram_cnt != '0) && (alloc_cnt < NB_PF_C);
  assign ret       = pipe_vld[RD_LAT-1];
  assign ret_idx   = pipe_idx[RD_LAT-1];
  assign occup_nxt = occup + (AWIDTH + 1)'(push) - (AWIDTH + 1)'(pop);

  always_ff @(posedge clk) begin
    if (to_bram) mem[wr_ptr] <= in_data;
    pipe_data[0] <= mem[rd_ptr];
    for (int i = 1; i < RD_LAT; i++) pipe_data[i] <= pipe_data[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      // flush mirrors reset except that space is advertised immediately
      in_ready    <= rst_n;
      occup       <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      bram_cnt    <= '0;
      head        <= '0;
      alloc       <= '0;
      alloc_cnt   <= '0;
      slot_vld    <= '0;
      pipe_vld    <= '0;
      for (int i = 0; i < NB_PF; i++) slot_data[i] <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_idx[i] <= '0;
    end else begin
      occup       <= occup_nxt;
      in_ready    <= occup_nxt < DEPTH_C;
      almost_full <= occup_nxt >= AFULL_C;
      if (in_valid && !in_ready) overflow <= 1'b1;

      if (to_bram) wr_ptr <= wr_ptr + 1'b1;
      if (issue)   rd_ptr <= rd_ptr + 1'b1;
      bram_cnt  <= bram_cnt + (AWIDTH + 1)'(to_bram) - (AWIDTH + 1)'(issue);
      alloc_cnt <= alloc_cnt + CW'(bypass || issue) - CW'(pop);

      if (bypass || issue) alloc <= slot_inc(alloc);
      if (pop) begin
        head           <= slot_inc(head);
        slot_vld[head] <= 1'b0;
      end
      if (bypass) begin
        slot_vld[alloc]  <= 1'b1;
        slot_data[alloc] <= in_data;
      end
      if (ret) begin
        slot_vld[ret_idx]  <= 1'b1;
        slot_data[ret_idx] <= pipe_data[RD_LAT-1];
      end

      pipe_vld[0] <= issue;
      pipe_idx[0] <= alloc;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  a_occup_max: assert property (@(posedge clk) disable iff (!rst_n) occup <= DEPTH_C);
  a_reads_max: assert property (@(posedge clk) disable iff (!rst_n) $countones(pipe_vld) <= RD_LAT);
  a_head_vld:  assert property (@(posedge clk) disable iff (!rst_n) out_valid == (occup != '0));

endmodule

// File: tb/tb_prefetch_stream_fifo.sv
// tb/tb_prefetch_stream_fifo.sv - self-checking bench against a queue-based reference model
module tb_prefetch_stream_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        flush = 0, in_valid = 0, out_ready = 0;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid, almost_full, overflow;
  logic [15:0] out_data;
  logic [4:0]  occup;

  prefetch_stream_fifo #(.DEPTH(16), .DWIDTH(16), .RD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .occup(occup), .almost_full(almost_full), .overflow(overflow)
  );

  // Bank of deeper instances, one per read latency, driven in lockstep.
  logic        b_flush = 0, b_in_valid = 0, b_out_ready = 0;
  logic [15:0] b_in_data = '0;
  logic        b_in_ready [4];
  logic        b_out_valid [4];
  logic        b_almost_full [4];
  logic        b_overflow [4];
  logic [15:0] b_out_data [4];
  logic [6:0]  b_occup [4];

  for (genvar g = 0; g < 4; g++) begin : g_bank
    prefetch_stream_fifo #(.DEPTH(64), .DWIDTH(16), .RD_LAT(g + 1)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(b_flush),
      .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready[g]),
      .out_data(b_out_data[g]), .out_valid(b_out_valid[g]), .out_ready(b_out_ready),
      .occup(b_occup[g]), .almost_full(b_almost_full[g]), .overflow(b_overflow[g])
    );
  end

  int checks = 0;
  int errors = 0;
  logic [15:0] mq[$];
  bit movf = 0;

  task automatic step(input bit iv, input logic [15:0] d, input bit ordy, input bit fl);
    bit pu, po;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    @(posedge clk);
    if (fl) begin
      mq.delete();
      movf = 0;
    end else begin
      pu = iv && (mq.size() < 16);
      po = ordy && (mq.size() > 0);
      if (iv && !pu) movf = 1;
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic bstep(input bit iv, input logic [15:0] d, input bit ordy, input bit fl);
    b_in_valid = iv; b_in_data = d; b_out_ready = ordy; b_flush = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (occup !== 0 || in_ready !== 0 || out_valid !== 0 || almost_full !== 0 || overflow !== 0 || out_data !== 0) begin
      errors++;
      $display("FAIL reset_state: occup=%0d rdy=%b vld=%b af=%b ovf=%b data=%h, want all 0", occup, in_ready, out_valid, almost_full, overflow, out_data);
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1 || occup !== 0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b occup=%0d, want 1 and 0", in_ready, occup);
    end
  endtask

  task automatic test_first_push();
    step(1, 16'hA5, 0, 0);
    checks++;
    if (out_valid !== 1 || out_data !== 16'hA5 || occup !== 1) begin
      errors++;
      $display("FAIL first_push: vld=%b data=%h occup=%0d, want 1 a5 1", out_valid, out_data, occup);
    end
    step(0, 0, 1, 0);
    checks++;
    if (out_valid !== 0 || occup !== 0) begin
      errors++;
      $display("FAIL first_pop: vld=%b occup=%0d, want 0 0", out_valid, occup);
    end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 16; i++) begin
      step(1, 16'(i), 0, 0);
      checks++;
      if (occup !== 5'(i + 1) || almost_full !== (i + 1 >= 8) || in_ready !== (i + 1 < 16) || overflow !== 0) begin
        errors++;
        $display("FAIL fill_%0d: occup=%0d af=%b rdy=%b ovf=%b, want %0d %b %b 0", i, occup, almost_full, in_ready, overflow, i + 1, i + 1 >= 8, i + 1 < 16);
      end
    end
    step(1, 16'd99, 0, 0);
    checks++;
    if (overflow !== 1 || occup !== 16 || in_ready !== 0) begin
      errors++;
      $display("FAIL overflow: ovf=%b occup=%0d rdy=%b, want 1 16 0", overflow, occup, in_ready);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_valid !== 1 || out_data !== 16'(i)) begin
        errors++;
        $display("FAIL drain_%0d: vld=%b data=%h, want 1 %h", i, out_valid, out_data, 16'(i));
      end
      step(i == 0, 16'd77, 1, 0);
    end
    checks++;
    if (occup !== 0 || out_valid !== 0 || overflow !== 1) begin
      errors++;
      $display("FAIL drained: occup=%0d vld=%b ovf=%b, want 0 0 1", occup, out_valid, overflow);
    end
    step(0, 0, 0, 1);
    checks++;
    if (overflow !== 0 || in_ready !== 1) begin
      errors++;
      $display("FAIL flush_clears_ovf: ovf=%b rdy=%b, want 0 1", overflow, in_ready);
    end
  endtask

  task automatic test_random();
    logic [15:0] eh;
    int bad;
    bad = 0;
    for (int c = 0; c < 10000 && bad < 50; c++) begin
      int pp;
      bit iv, ordy, fl;
      pp   = ((c / 200) % 2 == 0) ? 75 : 25;
      iv   = ($urandom_range(99) < pp);
      ordy = ($urandom_range(99) >= pp);
      fl   = ($urandom_range(999) == 0);
      step(iv, 16'($urandom), ordy, fl);
      eh = (mq.size() != 0) ? mq[0] : 16'h0;
      checks++;
      if (occup !== 5'(mq.size()) || out_valid !== (mq.size() != 0) || in_ready !== (mq.size() < 16) ||
          almost_full !== (mq.size() >= 8) || overflow !== movf || (mq.size() != 0 && out_data !== eh)) begin
        errors++;
        bad++;
        $display("FAIL random_%0d: occup=%0d vld=%b data=%h rdy=%b af=%b ovf=%b, want occup=%0d head=%h ovf=%b",
                 c, occup, out_valid, out_data, in_ready, almost_full, overflow, mq.size(), eh, movf);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    step(0, 0, 0, 1);
    for (int i = 0; i < 12; i++) step(1, 16'(i + 200), 0, 0);
    step(1, 16'd300, 1, 0);
    step(1, 16'd301, 1, 0);
    rst_n = 0;
    #1;
    mq.delete();
    movf = 0;
    checks++;
    if (occup !== 0 || out_valid !== 0 || in_ready !== 0 || almost_full !== 0 || overflow !== 0 || out_data !== 0) begin
      errors++;
      $display("FAIL async_reset: occup=%0d vld=%b rdy=%b af=%b ovf=%b data=%h, want all 0", occup, out_valid, in_ready, almost_full, overflow, out_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if (out_valid !== 0 || occup !== 0) begin
        errors++;
        $display("FAIL stale_after_reset_%0d: vld=%b occup=%0d, want 0 0", i, out_valid, occup);
      end
    end
    step(1, 16'h33, 0, 0);
    checks++;
    if (out_valid !== 1 || out_data !== 16'h33 || occup !== 1) begin
      errors++;
      $display("FAIL push_after_reset: vld=%b data=%h occup=%0d, want 1 33 1", out_valid, out_data, occup);
    end
    step(0, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) bstep(1, 16'(i), 0, 0);
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (b_occup[g] !== 7'd40) begin
        errors++;
        $display("FAIL b2b_fill lat%0d: occup=%0d, want 40", g + 1, b_occup[g]);
      end
    end
    for (int k = 0; k < 40; k++) begin
      for (int g = 0; g < 4; g++) begin
        checks++;
        if (b_out_valid[g] !== 1 || b_out_data[g] !== 16'(k)) begin
          errors++;
          $display("FAIL b2b lat%0d pop%0d: vld=%b data=%h, want 1 %h", g + 1, k, b_out_valid[g], b_out_data[g], 16'(k));
        end
      end
      bstep(0, 0, 1, 0);
    end
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (b_out_valid[g] !== 0 || b_occup[g] !== 0) begin
        errors++;
        $display("FAIL b2b_empty lat%0d: vld=%b occup=%0d, want 0 0", g + 1, b_out_valid[g], b_occup[g]);
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 20; i++) bstep(1, 16'(i + 16'h100), 0, 0);
    bstep(0, 0, 1, 0);
    bstep(0, 0, 0, 0);
    bstep(1, 16'h55, 1, 1);
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (b_occup[g] !== 0 || b_out_valid[g] !== 0 || b_in_ready[g] !== 1 || b_out_data[g] !== 0 ||
          b_almost_full[g] !== 0 || b_overflow[g] !== 0) begin
        errors++;
        $display("FAIL flush lat%0d: occup=%0d vld=%b rdy=%b data=%h, want 0 0 1 0", g + 1, b_occup[g], b_out_valid[g], b_in_ready[g], b_out_data[g]);
      end
    end
    bstep(1, 16'h7, 0, 0);
    for (int c = 0; c < 7; c++) begin
      for (int g = 0; g < 4; g++) begin
        checks++;
        if (b_out_valid[g] !== 1 || b_out_data[g] !== 16'h7 || b_occup[g] !== 1) begin
          errors++;
          $display("FAIL post_flush lat%0d c%0d: vld=%b data=%h occup=%0d, want 1 7 1", g + 1, c, b_out_valid[g], b_out_data[g], b_occup[g]);
        end
      end
      if (c < 6) bstep(0, 0, 0, 0);
    end
    bstep(0, 0, 1, 0);
    repeat (6) bstep(0, 0, 0, 0);
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (b_out_valid[g] !== 0 || b_occup[g] !== 0) begin
        errors++;
        $display("FAIL post_flush_empty lat%0d: vld=%b occup=%0d, want 0 0", g + 1, b_out_valid[g], b_occup[g]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_push();
    test_full_overflow();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
